ift_tag_sequencer: RTL

IFT_TAG_SEQUENCER -- requirements
Module: ift_tag_sequencer

---
 rtl/ift_tag_sequencer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/ift_tag_sequencer.sv
// ift_tag_sequencer
//   Stores a small table of taint-tag vectors (a/b/s tags plus a hold duration)
//   and plays them back into a tracked design. Each entry is held for
//   max(dur,1) cycles. While the table plays, the sequencer counts the cycles in
//   which the tracked design returns a nonzero output tag.
//
//   Optional feature: define IFT_SEQ_LOOP_EN to make playback wrap from the last
//   entry back to entry 0 until stop or rst. Without the macro the table
//   plays once.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   ld_valid / ld_ready      load handshake for one table entry (IDLE only)
//   ld_a_t, ld_b_t, ld_s_t   tags of the entry being loaded
//   ld_dur                   hold duration of the entry being loaded
//   start, stop              begin playback (IDLE) / abort playback (PLAY)
//   a_t, b_t, s_t            tags driven into the tracked design (zero outside PLAY)
//   c_t                      output tag returned by the tracked design
//   busy, done               playback active / one-cycle completion pulse
//   taint_cnt                saturating count of PLAY cycles with c_t != 0
//   entry_idx                index of the entry currently driven
//
// All outputs come from registers, so no input reaches an output
// combinationally.
module ift_tag_sequencer #(
  parameter int DEPTH = 16,
  parameter int TAG_W = 32,
  parameter int DUR_W = 16,
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = IW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [TAG_W-1:0] ld_a_t,
  input  logic [TAG_W-1:0] ld_b_t,
  input  logic [TAG_W-1:0] ld_s_t,
  input  logic [DUR_W-1:0] ld_dur,
  input  logic             start,
  input  logic             stop,
  output logic [TAG_W-1:0] a_t,
  output logic [TAG_W-1:0] b_t,
  output logic [TAG_W-1:0] s_t,
  input  logic [TAG_W-1:0] c_t,
  output logic             busy,
  output logic             done,
  output logic [15:0]      taint_cnt,
  output logic [IW-1:0]    entry_idx
);

  typedef enum logic [1:0] {IDLE, PLAY, FIN} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [DUR_W-1:0] hold_q, hold_d;
  logic [15:0]      taint_q, taint_d;
  logic             wr_en;

  logic [TAG_W-1:0] a_mem [DEPTH];
  logic [TAG_W-1:0] b_mem [DEPTH];
  logic [TAG_W-1:0] s_mem [DEPTH];
  logic [DUR_W-1:0] d_mem [DEPTH];

  logic [DUR_W-1:0] eff_dur;
  logic             expire;
  logic             last;

  // hold_q counts elapsed cycles of the current entry; a zero duration is
  // stretched to one cycle so every entry is visible at least once.
  always_comb begin
    eff_dur = (d_mem[idx_q] == '0) ? DUR_W'(1) : d_mem[idx_q];
    expire  = (hold_q == eff_dur - DUR_W'(1));
    last    = ({1'b0, idx_q} == cnt_q - CW'(1));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    taint_d = taint_q;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ld_valid && ld_ready) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + CW'(1);
        end
        // A load in the same cycle counts toward the start decision.
        if (start) begin
          if (cnt_d != '0) begin
            state_d = PLAY;
            idx_d   = '0;
            hold_d  = '0;
            taint_d = '0;
          end else begin
            state_d = FIN;
          end
        end
      end
      PLAY: begin
        if ((c_t != '0) && (taint_q != 16'hFFFF)) begin
          taint_d = taint_q + 16'd1;
        end
        // stop wins over hold expiry
        if (stop) begin
          state_d = FIN;
        end else if (expire) begin
          hold_d = '0;
          if (last) begin
`ifdef IFT_SEQ_LOOP_EN
            idx_d = '0;
`else
            state_d = FIN;
`endif
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          hold_d = hold_q + DUR_W'(1);
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      taint_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      taint_q <= taint_d;
    end
  end

  // Table storage carries no reset; contents are undefined after rst.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      a_mem[cnt_q[IW-1:0]] <= ld_a_t;
      b_mem[cnt_q[IW-1:0]] <= ld_b_t;
      s_mem[cnt_q[IW-1:0]] <= ld_s_t;
      d_mem[cnt_q[IW-1:0]] <= ld_dur;
    end
  end

  always_comb begin
    busy      = (state_q == PLAY);
    done      = (state_q == FIN);
    ld_ready  = (state_q == IDLE) && (cnt_q < CW'(DEPTH));
    a_t       = busy ? a_mem[idx_q] : '0;
    b_t       = busy ? b_mem[idx_q] : '0;
    s_t       = busy ? s_mem[idx_q] : '0;
    taint_cnt = taint_q;
    entry_idx = idx_q;
  end

endmodule
